// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: ISA field positions, opcodes,
// next-PC select encodings and the fetch state encoding.
package core_pkg;

    localparam int XLEN = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [1:0] MUX_PC_NEXT   = 2'b01;
    localparam logic [1:0] MUX_PC_BRANCH = 2'b10;
    localparam logic [1:0] MUX_PC_JUMP   = 2'b11;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int SIMM7_MSB  = 6;
    localparam int SIMM7_LSB  = 0;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC select: sequential, PC-relative branch (signed 7-bit offset) or
// register jump. All arithmetic wraps modulo 2^XLEN.
module next_pc_gen #(
    parameter int XLEN = 16
) (
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      simm7,
    input  logic [1:0]      mux_pc,
    input  logic [XLEN-1:0] jump_tgt,
    output logic [XLEN-1:0] pc_plus1,
    output logic [XLEN-1:0] next_pc
);
    import core_pkg::*;

    logic [XLEN-1:0] simm_ext;

    assign pc_plus1 = pc + XLEN'(1);
    assign simm_ext = {{(XLEN-7){simm7[6]}}, simm7};

    always_comb begin
        next_pc = pc_plus1;
        case (mux_pc)
            MUX_PC_BRANCH: next_pc = pc_plus1 + simm_ext;
            MUX_PC_JUMP:   next_pc = jump_tgt;
            default:       next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory request at a time and
// holds the returned instruction until execute consumes it.
//
// state | meaning
// REQ   | request valid at pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for the single response pulse
// HOLD  | instruction valid, waiting for exec_ready to advance pc
module fetch_unit #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [2:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus1,
    input  logic            exec_ready,
    input  logic [1:0]      mux_pc,
    input  logic [XLEN-1:0] jump_tgt,
    output logic [XLEN-1:0] retire_count
);
    import core_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] retire_q;
    logic [XLEN-1:0] next_pc;
    logic            capture;
    logic            retire;

    next_pc_gen #(.XLEN(XLEN)) u_next_pc (
        .pc       (pc_q),
        .simm7    (instr_q[SIMM7_MSB:SIMM7_LSB]),
        .mux_pc   (mux_pc),
        .jump_tgt (jump_tgt),
        .pc_plus1 (pc_plus1),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q <= imem_resp_data;
            end
            if (retire) begin
                pc_q     <= next_pc;
                retire_q <= retire_q + XLEN'(1);
            end
        end
    end

    // Responses and exec_ready are only acted on in their own state.
    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        retire         = 1'b0;
        imem_req_valid = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    capture = 1'b1;
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (exec_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    assign imem_req_addr = pc_q;
    assign instr_valid   = (state_q == FETCH_HOLD);
    assign instr         = instr_q;
    assign opcode        = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign pc            = pc_q;
    assign retire_count  = retire_q;

endmodule
